// File: rtl/latch_arb_ctl.sv
// Two-requester arbiter that sequences a shared 74S373 latch through
// setup, transparent, hold and output-drive phases for each transfer.
module latch_arb_ctl (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] din0,
    input  logic [7:0] din1,
    input  logic [2:0] drv_cycles,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] lat_d,
    output logic       lat_hold_n,
    output logic       lat_oenb_n,
    output logic       busy,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        OPEN    = 3'd2,
        CLOSE   = 3'd3,
        DRIVE   = 3'd4,
        RELEASE = 3'd5
    } state_t;

    state_t     state;
    logic [3:0] drv_cnt;
    logic       last_served;
    logic       win1;

    // Handshake: req is sampled only in IDLE; gnt is held from SETUP through
    // RELEASE and done pulses for the RELEASE cycle. Dropping req mid-transfer
    // does not abort it.
    // On a tie, last_served=1 means requester 1 went last, so requester 0 wins.
    assign win1      = req1 & (~req0 | ~last_served);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            busy        <= 1'b0;
            lat_hold_n  <= 1'b0;
            lat_oenb_n  <= 1'b1;
            lat_d       <= 8'h00;
            drv_cnt     <= 4'd0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state       <= SETUP;
                        busy        <= 1'b1;
                        gnt0        <= ~win1;
                        gnt1        <= win1;
                        last_served <= win1;
                        lat_d       <= win1 ? din1 : din0;
                        drv_cnt     <= (drv_cycles == 3'd0) ? 4'd8 : {1'b0, drv_cycles};
                    end
                end
                SETUP: begin
                    state      <= OPEN;
                    lat_hold_n <= 1'b1;
                end
                OPEN: begin
                    state      <= CLOSE;
                    lat_hold_n <= 1'b0;
                end
                CLOSE: begin
                    state      <= DRIVE;
                    lat_oenb_n <= 1'b0;
                end
                DRIVE: begin
                    drv_cnt <= drv_cnt - 4'd1;
                    if (drv_cnt == 4'd1) begin
                        state      <= RELEASE;
                        lat_oenb_n <= 1'b1;
                        done0      <= gnt0;
                        done1      <= gnt1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_arb_ctl.sv
// Directed bench for latch_arb_ctl: single transfer, tie alternation, maximum
// drive, input isolation and reset during DRIVE, plus per-cycle invariants.
module tb_latch_arb_ctl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] din0 = 8'h00;
    logic [7:0] din1 = 8'h00;
    logic [2:0] drv_cycles = 3'd0;
    logic       gnt0, gnt1, done0, done1, lat_hold_n, lat_oenb_n, busy;
    logic [7:0] lat_d;
    logic [2:0] dbg_state;

    int n_pass = 0;
    int n_total = 0;

    latch_arb_ctl dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .din0       (din0),
        .din1       (din1),
        .drv_cycles (drv_cycles),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .done0      (done0),
        .done1      (done1),
        .lat_d      (lat_d),
        .lat_hold_n (lat_hold_n),
        .lat_oenb_n (lat_oenb_n),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the sampling edge (first SETUP cycle); walks the whole
    // transfer and the following IDLE cycle.
    task automatic xfer_check(input int who, input logic [7:0] data, input int n, input bit perturb);
        int hold_hi = 0;
        int oe_lo = 0;
        int dn = 0;
        int gcnt = 0;
        logic [2:0] es;
        for (int c = 0; c < n + 4; c++) begin
            es = (c == 0) ? 3'd1 : (c == 1) ? 3'd2 : (c == 2) ? 3'd3 :
                 (c == n + 3) ? 3'd5 : 3'd4;
            chk("state", 32'(dbg_state), 32'(es));
            chk("gnt0", 32'(gnt0), 32'(who == 0));
            chk("gnt1", 32'(gnt1), 32'(who == 1));
            chk("lat_d", 32'(lat_d), 32'(data));
            chk("hold_n", 32'(lat_hold_n), 32'(es == 3'd2));
            chk("oenb_n", 32'(lat_oenb_n), 32'(es != 3'd4));
            chk("done0", 32'(done0), 32'(who == 0 && es == 3'd5));
            chk("done1", 32'(done1), 32'(who == 1 && es == 3'd5));
            chk("busy", 32'(busy), 32'd1);
            if (lat_hold_n) hold_hi++;
            if (!lat_oenb_n) oe_lo++;
            if (done0 | done1) dn++;
            if (gnt0 | gnt1) gcnt++;
            if (perturb && c == 1) begin
                din1 = 8'hFF;
                drv_cycles = 3'd7;
            end
            step();
        end
        chk("idle_state", 32'(dbg_state), 32'd0);
        chk("idle_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("idle_done", 32'({done1, done0}), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_oenb", 32'(lat_oenb_n), 32'd1);
        chk("idle_hold", 32'(lat_hold_n), 32'd0);
        chk("hold_cycles", 32'(hold_hi), 32'd1);
        chk("oe_cycles", 32'(oe_lo), 32'(n));
        chk("done_cycles", 32'(dn), 32'd1);
        chk("gnt_cycles", 32'(gcnt), 32'(n + 4));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("inv_hold_oe", 32'(lat_hold_n & ~lat_oenb_n), 32'd0);
            chk("inv_gnt", 32'(gnt0 & gnt1), 32'd0);
            chk("inv_done", 32'((done0 | done1) && dbg_state != 3'd5), 32'd0);
        end
    end

    initial begin
        // Reset values
        step();
        step();
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("rst_done", 32'({done1, done0}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hold", 32'(lat_hold_n), 32'd0);
        chk("rst_oenb", 32'(lat_oenb_n), 32'd1);
        chk("rst_lat_d", 32'(lat_d), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_no_req", 32'(dbg_state), 32'd0);

        // Single request, N=2
        req0 = 1'b1; din0 = 8'hA5; drv_cycles = 3'd2;
        step();
        req0 = 1'b0;
        xfer_check(0, 8'hA5, 2, 1'b0);

        // Tie after reset alternates 0,1,0,1
        reset = 1'b1;
        #1;
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; din0 = 8'h11; din1 = 8'h22; drv_cycles = 3'd1;
        step();
        xfer_check(0, 8'h11, 1, 1'b0);
        step();
        xfer_check(1, 8'h22, 1, 1'b0);
        step();
        xfer_check(0, 8'h11, 1, 1'b0);
        step();
        xfer_check(1, 8'h22, 1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;

        // Maximum drive: 0 encodes 8
        req0 = 1'b1; din0 = 8'h5C; drv_cycles = 3'd0;
        step();
        req0 = 1'b0;
        xfer_check(0, 8'h5C, 8, 1'b0);

        // Input isolation: din1/drv_cycles change during OPEN
        req1 = 1'b1; din1 = 8'h3C; drv_cycles = 3'd1;
        step();
        req1 = 1'b0;
        xfer_check(1, 8'h3C, 1, 1'b1);

        // Reset during DRIVE
        req0 = 1'b1; din0 = 8'h5A; drv_cycles = 3'd4;
        step();
        req0 = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_drive", 32'(dbg_state), 32'd4);
        reset = 1'b1;
        #1;
        chk("arst_state", 32'(dbg_state), 32'd0);
        chk("arst_oenb", 32'(lat_oenb_n), 32'd1);
        chk("arst_hold", 32'(lat_hold_n), 32'd0);
        chk("arst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_lat_d", 32'(lat_d), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_done", 32'({done1, done0}), 32'd0);
            chk("post_rst_idle", 32'(dbg_state), 32'd0);
        end
        req0 = 1'b1; din0 = 8'h77; drv_cycles = 3'd3;
        step();
        req0 = 1'b0;
        xfer_check(0, 8'h77, 3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
